// File: rtl/kbd_pkg.sv
// Shared types, selector codes, joystick bit positions and the scancode-to-matrix map
// for the keyboard matrix emulator.
package kbd_pkg;

  typedef struct packed {
    logic       hit;
    logic [3:0] col;
    logic [2:0] row;
  } key_entry_t;

  typedef struct packed {
    logic       ext;
    logic [7:0] code;
    logic [3:0] col;
    logic [2:0] row;
  } map_row_t;

  localparam logic [7:0] SEL_JOY1 = 8'h30;
  localparam logic [7:0] SEL_JOY2 = 8'h40;

  localparam int JOY_R  = 0;
  localparam int JOY_L  = 1;
  localparam int JOY_D  = 2;
  localparam int JOY_U  = 3;
  localparam int JOY_B1 = 4;
  localparam int JOY_B2 = 5;

  // Both Shift scancodes land on the same matrix bit.
  localparam int MAP_LEN = 5;
  localparam map_row_t KEY_MAP [MAP_LEN] = '{
    '{1'b0, 8'h1C, 4'd3, 3'd1},
    '{1'b0, 8'h5A, 4'd7, 3'd0},
    '{1'b1, 8'h75, 4'd8, 3'd0},
    '{1'b0, 8'h12, 4'd0, 3'd6},
    '{1'b0, 8'h59, 4'd0, 3'd6}
  };

  function automatic logic [7:0] joy_rows(input logic [5:0] j);
    return {2'b00, j[JOY_B2], j[JOY_B1], j[JOY_U], j[JOY_D], j[JOY_L], j[JOY_R]};
  endfunction

endpackage

// File: rtl/kbd_matrix_if.sv
// Keyboard/joystick input and CPU-facing row readback bundle for kbd_matrix.
interface kbd_matrix_if;
  logic [10:0] ps2_key;
  logic [7:0]  kb_cols;
  logic [31:0] joy1;
  logic [31:0] joy2;
  logic [7:0]  kb_rows;
  logic        key_evt;

  modport master (output ps2_key, kb_cols, joy1, joy2, input kb_rows, key_evt);
  modport slave  (input ps2_key, kb_cols, joy1, joy2, output kb_rows, key_evt);
endinterface

// File: rtl/kbd_keymap.sv
// Registered scancode lookup: turns a stage-1 key event into {hit, col, row}.
module kbd_keymap
  import kbd_pkg::*;
#(
  parameter int NCOLS = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid,
  input  logic       ext,
  input  logic       pressed,
  input  logic [7:0] code,
  output key_entry_t entry,
  output logic       entry_pressed
);

  key_entry_t look;

  always_comb begin
    look = '0;
    for (int i = 0; i < MAP_LEN; i++) begin
      if (KEY_MAP[i].ext == ext && KEY_MAP[i].code == code) begin
        look.hit = 1'b1;
        look.col = KEY_MAP[i].col;
        look.row = KEY_MAP[i].row;
      end
    end
    // Columns beyond the configured matrix width behave as unmapped.
    if (!valid || look.col >= 4'(NCOLS)) look.hit = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry         <= '0;
      entry_pressed <= 1'b0;
    end else begin
      entry         <= look;
      entry_pressed <= pressed;
    end
  end

endmodule

// File: rtl/kbd_matrix.sv
// PS/2 key events to an NCOLS x 8 key matrix, read back column-by-column (or as a
// joystick) through a CPU column-select register.
module kbd_matrix
  import kbd_pkg::*;
#(
  parameter int NCOLS    = 9,
  parameter bit JOY_SWAP = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  kbd_matrix_if.slave  bus
);

  localparam logic [7:0] SEL_A = JOY_SWAP ? SEL_JOY2 : SEL_JOY1;
  localparam logic [7:0] SEL_B = JOY_SWAP ? SEL_JOY1 : SEL_JOY2;

  logic       tog_q;
  logic       sync_pend;
  logic       new_evt;
  logic       s1_valid;
  logic       s1_ext;
  logic       s1_pressed;
  logic [7:0] s1_code;
  key_entry_t s2_entry;
  logic       s2_pressed;
  logic [7:0] matrix [NCOLS];
  logic       evt_q;
  logic [7:0] rows_d;
  logic [7:0] rows_q;
  logic       unused_joy;

  assign unused_joy = ^{bus.joy1[31:6], bus.joy2[31:6]};

  // The first edge after reset only captures the toggle level, so a stale toggle is not an event.
  assign new_evt = (bus.ps2_key[10] ^ tog_q) & ~sync_pend;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tog_q      <= 1'b0;
      sync_pend  <= 1'b1;
      s1_valid   <= 1'b0;
      s1_ext     <= 1'b0;
      s1_pressed <= 1'b0;
      s1_code    <= 8'h00;
    end else begin
      tog_q      <= bus.ps2_key[10];
      sync_pend  <= 1'b0;
      s1_valid   <= new_evt;
      s1_ext     <= bus.ps2_key[8];
      s1_pressed <= bus.ps2_key[9];
      s1_code    <= bus.ps2_key[7:0];
    end
  end

  kbd_keymap #(.NCOLS(NCOLS)) u_keymap (
    .clk           (clk),
    .reset         (reset),
    .valid         (s1_valid),
    .ext           (s1_ext),
    .pressed       (s1_pressed),
    .code          (s1_code),
    .entry         (s2_entry),
    .entry_pressed (s2_pressed)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NCOLS; c++) matrix[c] <= 8'h00;
      evt_q <= 1'b0;
    end else begin
      evt_q <= s2_entry.hit;
      for (int c = 0; c < NCOLS; c++) begin
        if (s2_entry.hit && s2_entry.col == 4'(c)) matrix[c][s2_entry.row] <= s2_pressed;
      end
    end
  end

  always_comb begin
    rows_d = 8'h00;
    if (bus.kb_cols == SEL_A) begin
      rows_d = joy_rows(bus.joy1[5:0]);
    end else if (bus.kb_cols == SEL_B) begin
      rows_d = joy_rows(bus.joy2[5:0]);
    end else if (bus.kb_cols[7:4] == 4'h0) begin
      for (int c = 0; c < NCOLS; c++) begin
        if (bus.kb_cols[3:0] == 4'(c + 1)) rows_d = matrix[c];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rows_q <= 8'h00;
    else       rows_q <= rows_d;
  end

  assign bus.kb_rows = rows_q;
  assign bus.key_evt = evt_q;

endmodule

// File: tb/tb_kbd_matrix.sv
// Directed bench for kbd_matrix: a default instance plus a JOY_SWAP=1, NCOLS=8 instance.
module tb_kbd_matrix;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  kbd_matrix_if bus ();
  kbd_matrix_if bus2 ();

  kbd_matrix #(.NCOLS(9), .JOY_SWAP(1'b0)) dut  (.clk(clk), .reset(reset), .bus(bus));
  kbd_matrix #(.NCOLS(8), .JOY_SWAP(1'b1)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  cols;
    logic [31:0] j1;
    logic [31:0] j2;
    logic [7:0]  exp;
    logic [7:0]  exp_sw;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic ext, input logic pressed, input logic [7:0] code);
    bus.ps2_key = {~bus.ps2_key[10], pressed, ext, code};
  endtask

  task automatic send2(input logic ext, input logic pressed, input logic [7:0] code);
    bus2.ps2_key = {~bus2.ps2_key[10], pressed, ext, code};
  endtask

  // Watches key_evt for 6 cycles after an event is driven; checks pulse count and first-pulse cycle.
  task automatic expect_evt(input string name, input int exp_n, input int exp_first);
    int n = 0;
    int first = 0;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      if (bus.key_evt === 1'b1) begin
        n++;
        if (first == 0) first = k;
      end
    end
    check({name, " evt count"}, n, exp_n);
    if (exp_n > 0) check({name, " evt latency"}, first, exp_first);
  endtask

  task automatic expect_evt2(input string name, input int exp_n);
    int n = 0;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      if (bus2.key_evt === 1'b1) n++;
    end
    check({name, " evt count"}, n, exp_n);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.ps2_key  = 11'h400;
    bus.kb_cols  = 8'h00;
    bus.joy1     = 32'h0;
    bus.joy2     = 32'h0;
    bus2.ps2_key = 11'h400;
    bus2.kb_cols = 8'h00;
    bus2.joy1    = 32'h0;
    bus2.joy2    = 32'h0;

    vecs[0]  = '{8'h01, 32'h0, 32'h0, 8'h40, 8'h00};
    vecs[1]  = '{8'h04, 32'h0, 32'h0, 8'h00, 8'h02};
    vecs[2]  = '{8'h08, 32'h0, 32'h0, 8'h01, 8'h00};
    vecs[3]  = '{8'h09, 32'h0, 32'h0, 8'h01, 8'h00};
    vecs[4]  = '{8'h00, 32'h0, 32'h0, 8'h00, 8'h00};
    vecs[5]  = '{8'h0A, 32'h0, 32'h0, 8'h00, 8'h00};
    vecs[6]  = '{8'h11, 32'h0, 32'h0, 8'h00, 8'h00};
    vecs[7]  = '{8'h30, 32'h11, 32'h08, 8'h11, 8'h08};
    vecs[8]  = '{8'h40, 32'h11, 32'h08, 8'h08, 8'h11};
    vecs[9]  = '{8'h55, 32'h11, 32'h08, 8'h00, 8'h00};
    vecs[10] = '{8'h30, 32'hFFFF_FFFF, 32'h0, 8'h3F, 8'h00};
    vecs[11] = '{8'h40, 32'h25, 32'hFFFF_FFC0, 8'h00, 8'h25};
    vecs[12] = '{8'h31, 32'h3F, 32'h3F, 8'h00, 8'h00};

    #1 reset = 1'b1;
    step(2);
    check("reset kb_rows", bus.kb_rows, 8'h00);
    check("reset key_evt", bus.key_evt, 1'b0);
    reset = 1'b0;
    expect_evt("post-reset idle", 0, 0);
    expect_evt2("dut2 post-reset idle", 0);

    // Press A with column 4 selected
    bus.kb_cols = 8'h04;
    send(1'b0, 1'b1, 8'h1C);
    expect_evt("press A", 1, 3);
    check("A col4", bus.kb_rows, 8'h02);

    send(1'b0, 1'b1, 8'h5A);
    expect_evt("press Enter", 1, 3);

    send(1'b0, 1'b0, 8'h1C);
    expect_evt("release A", 1, 3);
    check("A released col4", bus.kb_rows, 8'h00);

    bus.kb_cols = 8'h08;
    step(1);
    check("Enter col8 one cycle", bus.kb_rows, 8'h01);

    // Back-to-back toggles on consecutive cycles
    send(1'b1, 1'b1, 8'h75);
    step(1);
    send(1'b0, 1'b1, 8'h12);
    expect_evt("b2b Up+Shift", 2, 2);
    bus.kb_cols = 8'h09;
    step(1);
    check("Up col9", bus.kb_rows, 8'h01);
    bus.kb_cols = 8'h01;
    step(1);
    check("Shift col1", bus.kb_rows, 8'h40);

    send(1'b0, 1'b0, 8'h59);
    expect_evt("break 0x59", 1, 3);
    check("shared shift cleared", bus.kb_rows, 8'h00);
    send(1'b0, 1'b1, 8'h12);
    expect_evt("make 0x12", 1, 3);
    send(1'b0, 1'b1, 8'h12);
    step(6);
    check("repeat make idempotent", bus.kb_rows, 8'h40);

    bus.kb_cols = 8'h04;
    send(1'b0, 1'b0, 8'h1C);
    step(6);
    check("break not held", bus.kb_rows, 8'h00);

    // Column switch one cycle before the matrix write
    bus.kb_cols = 8'h01;
    send(1'b0, 1'b1, 8'h1C);
    step(2);
    bus.kb_cols = 8'h04;
    step(1);
    check("col switch before update", bus.kb_rows, 8'h00);
    step(1);
    check("col switch after update", bus.kb_rows, 8'h02);
    send(1'b0, 1'b0, 8'h1C);
    expect_evt("release A again", 1, 3);

    send(1'b0, 1'b1, 8'h7E);
    expect_evt("unmapped 0x7E", 0, 0);

    send2(1'b1, 1'b1, 8'h75);
    expect_evt2("dut2 Up col>=NCOLS", 0);
    send2(1'b0, 1'b1, 8'h1C);
    expect_evt2("dut2 press A", 1);

    for (int i = 0; i < 13; i++) begin
      bus.kb_cols  = vecs[i].cols;
      bus.joy1     = vecs[i].j1;
      bus.joy2     = vecs[i].j2;
      bus2.kb_cols = vecs[i].cols;
      bus2.joy1    = vecs[i].j1;
      bus2.joy2    = vecs[i].j2;
      step(1);
      check($sformatf("vec%0d kb_cols=%0h", i, vecs[i].cols), bus.kb_rows, vecs[i].exp);
      check($sformatf("vec%0d swap kb_cols=%0h", i, vecs[i].cols), bus2.kb_rows, vecs[i].exp_sw);
    end
    bus.joy1 = 32'h0;
    bus.joy2 = 32'h0;

    // Reset two cycles into an A make; Enter is held across the reset
    bus.kb_cols = 8'h08;
    step(1);
    check("Enter before reset", bus.kb_rows, 8'h01);
    send(1'b0, 1'b1, 8'h1C);
    step(2);
    reset = 1'b1;
    #1;
    check("mid reset kb_rows", bus.kb_rows, 8'h00);
    check("mid reset key_evt", bus.key_evt, 1'b0);
    step(2);
    reset = 1'b0;
    bus.kb_cols = 8'h04;
    expect_evt("after reset release", 0, 0);
    check("A discarded", bus.kb_rows, 8'h00);
    bus.kb_cols = 8'h08;
    step(1);
    check("Enter released by reset", bus.kb_rows, 8'h00);
    bus.kb_cols = 8'h01;
    step(1);
    check("Shift released by reset", bus.kb_rows, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kbd_matrix.md
KBD_MATRIX -- requirements
Module: kbd_matrix

Interface
REQ-001 Parameter: NCOLS, 9, number of keyboard matrix columns (valid range 1..15).
REQ-002 Parameter: JOY_SWAP, 0, 1 exchanges the joy1 and joy2 selector codes.
REQ-003 Port: clk  input  1  system clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: ps2_key  input  11  [7:0] scancode, [8] extended, [9] pressed, [10] event toggle.
REQ-006 Port: kb_cols  input  8  column select written by the CPU to port F4.
REQ-007 Port: joy1  input  32  player 1 joystick: [0] R, [1] L, [2] D, [3] U, [4] B1, [5] B2.
REQ-008 Port: joy2  input  32  player 2 joystick, same bit layout as joy1.
REQ-009 Port: kb_rows  output  8  active-high row data returned on a port F4 read.
REQ-010 Port: key_evt  output  1  one-cycle pulse when a mapped key changes the matrix.

Function
REQ-011 Event detect: a new event is any cycle where ps2_key[10] differs from its registered copy.
REQ-012 Every event is processed; back-to-back toggles on consecutive cycles are both handled, with no drop and no buffer.
REQ-013 Pipeline stage 1 registers {extended, pressed, scancode} and sets a valid bit.
REQ-014 Pipeline stage 2 looks up the key map and produces {hit, col[3:0], row[2:0]}; a miss clears hit.
REQ-015 Pipeline stage 3, when hit is set:
  - sets matrix[col][row] to the pressed bit;
  - pulses key_evt for one cycle.
REQ-016 Key event to matrix update is 3 cycles after the toggle edge is sampled.
REQ-017 Unmapped scancodes, and codes with col >= NCOLS, leave the matrix unchanged and produce no key_evt.
REQ-018 The matrix is NCOLS x 8 bits.
REQ-019 Repeated make codes are idempotent.
REQ-020 A break for a key that is not held is harmless.
REQ-021 Fixed map entries:
  - 0x1C (A) -> col 3, row 1;
  - 0x5A (Enter) -> col 7, row 0;
  - extended 0x75 (Up) -> col 8, row 0;
  - 0x12 or 0x59 (Shift) -> col 0, row 6.
  Both Shift codes share one matrix bit; the last event wins.
REQ-022 kb_cols decode (with JOY_SWAP=0):
  - low nibble 1..NCOLS with high nibble 0 selects matrix column (value-1);
  - 0x30 selects joy1;
  - 0x40 selects joy2;
  - any other value returns 0x00.
REQ-023 Joystick rows: {2'b0, B2, B1, U, D, L, R}, taken from the selected joystick sampled in the same clock.
REQ-024 kb_rows is registered: it reflects kb_cols and the matrix as of the previous clock edge (1-cycle latency).
REQ-025 If a matrix update and a kb_cols change land in the same cycle, kb_rows in the next cycle shows the updated matrix for the new column.

Reset
REQ-026 On reset assertion, asynchronously:
  - matrix = all zero;
  - pipeline valid/hit bits = 0;
  - kb_rows = 0x00;
  - key_evt = 0.
REQ-027 On reset, the toggle copy register loads the ps2_key[10] value present at deassertion, so no spurious event follows reset release.
REQ-028 A reset asserted mid-pipeline discards all in-flight events.
REQ-029 Keys held across a reset read as released until their next make code arrives.

Structure
REQ-030 Package kbd_pkg holds:
  - the key map entry type {hit, col, row};
  - selector constants 0x30 and 0x40;
  - joystick bit indices;
  - the scancode map table.
REQ-031 Sub-module kbd_keymap implements the stage-2 lookup (registered, 1 cycle); kbd_matrix instantiates it.
REQ-032 No other sub-modules.

Verification
REQ-033 Press A (ps2_key=0x21C, then toggle), kb_cols=0x04 -> kb_rows=0x02 at most 4 cycles later; key_evt pulses once.
REQ-034 Release A (pressed=0, toggle) -> kb_rows=0x00; then kb_cols=0x08 with Enter held -> kb_rows=0x01 one cycle after the write.
REQ-035 Two toggles on consecutive cycles (extended Up make, then 0x12 make) -> col 8 reads 0x01 and col 0 reads 0x40; key_evt pulses twice.
REQ-036 joy1=0x11 with kb_cols=0x30 -> 0x11; kb_cols=0x40 with joy2=0x08 -> 0x08; kb_cols=0x55 -> 0x00; with JOY_SWAP=1 the two selectors are exchanged.
REQ-037 Unmapped code 0x7E make -> no key_evt, every column reads 0x00.
REQ-038 Assert reset 2 cycles after a make toggle -> no matrix bit set, kb_rows=0x00, and no event after release even though ps2_key[10] is unchanged.
